// File: rtl/traffic_disp_pkg.sv
// Shared definitions for the traffic-light countdown display path.
//   state_t    : controller states (IDLE, CONV, COMMIT)
//   CONV_STEPS : number of shift-and-add-3 steps for an 8-bit value
//   BCD_W      : width of one BCD digit
//   BLANK_RST  : blank mask after reset (hundreds and tens dark, ones shows 0)
package traffic_disp_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam int         CONV_STEPS = 8;
  localparam int         BCD_W      = 4;
  localparam logic [2:0] BLANK_RST  = 3'b110;

endpackage

// File: rtl/disp_blink_timer.sv
// Blink phase generator for the countdown display.
// The phase toggles every CLK_HZ/(2*BLINK_HZ) clock cycles while en is high.
// While en is low, the prescaler and the phase are both held at 0, so the
// display is never left dark when blinking stops.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   en    : run the prescaler
//   phase : current blink phase (1 = blanked half-period)
module disp_blink_timer #(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic phase
);

  localparam int DIV   = CLK_HZ / (2 * BLINK_HZ);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (!en) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt == CNT_W'(DIV - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt   <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hex_countdown_ctrl.sv
// Countdown display controller: converts an 8-bit remaining-time value into
// three BCD digits for the HEX2..HEX0 decoders, with leading-zero blanking
// and an optional blink overlay.
// Conversion is a sequential shift-and-add-3 (double dabble), one step per
// cycle. Digits only change on the COMMIT edge, so the decoders never see
// partial results. A load that arrives during a conversion is parked in a
// single pending slot (newest value wins) and is converted right after the
// running conversion commits.
// Ports:
//   clk, rst_n     : clock, asynchronous active-low reset
//   load, value    : strobe and 8-bit binary value to display
//   blink_en       : enable blink overlay on all digits
//   busy           : conversion in progress (CONV or COMMIT)
//   digit2..digit0 : hundreds/tens/ones BCD digits
//   blank          : per-digit blank, bit i -> digit i, active-high
module hex_countdown_ctrl
  import traffic_disp_pkg::*;
#(
  parameter int CLK_HZ   = 50_000_000,
  parameter int BLINK_HZ = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [7:0]       value,
  input  logic             blink_en,
  output logic             busy,
  output logic [BCD_W-1:0] digit0,
  output logic [BCD_W-1:0] digit1,
  output logic [BCD_W-1:0] digit2,
  output logic [2:0]       blank
);

  localparam int ACC_W = 3 * BCD_W;

  state_t           state;
  logic [2:0]       step;
  logic [7:0]       bin_sr;
  logic [ACC_W-1:0] bcd;
  logic [ACC_W-1:0] bcd_adj;
  logic [7:0]       pend_val;
  logic             pend;
  logic [2:0]       lz;
  logic             phase;
  logic [2:0]       blink_mask;

  function automatic logic [BCD_W-1:0] add3(input logic [BCD_W-1:0] n);
    return (n >= BCD_W'(5)) ? n + BCD_W'(3) : n;
  endfunction

  function automatic logic [ACC_W-1:0] add3_all(input logic [ACC_W-1:0] b);
    logic [ACC_W-1:0] r;
    r = b;
    for (int i = 0; i < 3; i++) r[i*BCD_W +: BCD_W] = add3(b[i*BCD_W +: BCD_W]);
    return r;
  endfunction

  // Ones digit always shows; tens is dark only when hundreds is also zero.
  function automatic logic [2:0] lz_mask(input logic [ACC_W-1:0] b);
    return {b[3*BCD_W-1:2*BCD_W] == '0, b[3*BCD_W-1:BCD_W] == '0, 1'b0};
  endfunction

  disp_blink_timer #(
    .CLK_HZ  (CLK_HZ),
    .BLINK_HZ(BLINK_HZ)
  ) u_blink (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (blink_en),
    .phase(phase)
  );

  assign bcd_adj    = add3_all(bcd);
  assign blink_mask = {3{blink_en & phase}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      step     <= '0;
      bin_sr   <= '0;
      bcd      <= '0;
      pend_val <= '0;
      pend     <= 1'b0;
      lz       <= BLANK_RST;
      busy     <= 1'b0;
      digit0   <= '0;
      digit1   <= '0;
      digit2   <= '0;
      blank    <= BLANK_RST;
    end else begin
      blank <= lz | blink_mask;
      case (state)
        IDLE: begin
          if (load) begin
            bin_sr <= value;
            bcd    <= '0;
            step   <= '0;
            busy   <= 1'b1;
            state  <= CONV;
          end
        end
        CONV: begin
          bcd    <= {bcd_adj[ACC_W-2:0], bin_sr[7]};
          bin_sr <= {bin_sr[6:0], 1'b0};
          step   <= step + 3'd1;
          if (load) begin
            pend_val <= value;
            pend     <= 1'b1;
          end
          if (step == 3'(CONV_STEPS - 1)) state <= COMMIT;
        end
        COMMIT: begin
          digit0 <= bcd[BCD_W-1:0];
          digit1 <= bcd[2*BCD_W-1:BCD_W];
          digit2 <= bcd[3*BCD_W-1:2*BCD_W];
          lz     <= lz_mask(bcd);
          blank  <= lz_mask(bcd) | blink_mask;
          if (pend || load) begin
            // A parked value goes first; a load on this same edge takes its
            // place in the slot. With nothing parked the new load starts now.
            bin_sr <= pend ? pend_val : value;
            bcd    <= '0;
            step   <= '0;
            pend   <= pend & load;
            if (load) pend_val <= value;
            busy   <= 1'b1;
            state  <= CONV;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
